// File: rtl/rv32i_lsu.sv
// rv32i_lsu - load/store unit for the rv32i MA stage.
// Turns a core load/store into a stalling request/response sequence on a
// memory bus of BUS_WIDTH bits (16 or 32). Word accesses on a 16-bit bus are
// split into two beats (low half first). One transaction in flight at a time.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   op_valid/op_store/op_size/   core request (sampled only while busy=0)
//   op_unsigned/op_addr/op_wdata
//   busy                         stall: an accepted op is in flight
//   done                         one-cycle completion pulse
//   rdata                        extended load result, held until next load
//   misaligned                   one-cycle pulse for a rejected op
//   mem_addr/mem_we/mem_re/      bus command (held until mem_busy=0)
//   mem_wdata/mem_be
//   mem_busy/mem_rvalid/mem_rdata bus handshake and read return
//
// state  | meaning
// IDLE   | no op in flight, sampling op_valid
// ISSUE  | command on the bus, waiting for mem_busy=0
// WAIT_R | read accepted, waiting for mem_rvalid
module rv32i_lsu #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 22
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   op_valid,
  input  logic                   op_store,
  input  logic [1:0]             op_size,
  input  logic                   op_unsigned,
  input  logic [31:0]            op_addr,
  input  logic [31:0]            op_wdata,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            rdata,
  output logic                   misaligned,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_we,
  output logic                   mem_re,
  output logic [BUS_WIDTH-1:0]   mem_wdata,
  output logic [BUS_WIDTH/8-1:0] mem_be,
  input  logic                   mem_busy,
  input  logic                   mem_rvalid,
  input  logic [BUS_WIDTH-1:0]   mem_rdata
);

  localparam int NB = BUS_WIDTH / 8;
  localparam int OFFS = (BUS_WIDTH == 16) ? 1 : 2;
  localparam bit NARROW = (BUS_WIDTH == 16);
  localparam logic [1:0] LANE_MASK = 2'(NB - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R} state_t;

  state_t state, state_d;

  logic        store_q, unsigned_q, two_beat_q, beat_q;
  logic [1:0]  size_q, lane_q;
  logic [15:0] wdata_hi_q, lo_half_q;

  logic [1:0]            size_n, lane_in;
  logic                  mis_in, last_beat;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [31:0]           rd32, raw_rd, ext_rd;
  logic                  unused_addr;

  // Write data replicated across lanes so the byte enables alone pick the
  // target; the high half of a split word rides in the low lanes.
  function automatic logic [BUS_WIDTH-1:0] lane_wdata(input logic [1:0] sz,
                                                       input logic [31:0] wd);
    logic [31:0] full;
    case (sz)
      2'd0:    full = {4{wd[7:0]}};
      2'd1:    full = {2{wd[15:0]}};
      default: full = wd;
    endcase
    return full[BUS_WIDTH-1:0];
  endfunction

  function automatic logic [NB-1:0] lane_be(input logic [1:0] sz,
                                            input logic [1:0] lane);
    logic [3:0] full;
    case (sz)
      2'd0:    full = 4'b0001 << lane;
      2'd1:    full = 4'b0011 << lane;
      default: full = 4'b1111;
    endcase
    return full[NB-1:0];
  endfunction

  assign size_n      = (op_size == 2'd3) ? 2'd2 : op_size;
  assign lane_in     = op_addr[1:0] & LANE_MASK;
  assign mis_in      = ((size_n == 2'd1) && op_addr[0]) ||
                       ((size_n == 2'd2) && (op_addr[1:0] != 2'd0));
  assign base_addr   = op_addr[ADDR_WIDTH+OFFS-1:OFFS];
  assign unused_addr = ^op_addr[31:ADDR_WIDTH+OFFS];
  assign last_beat   = !two_beat_q || beat_q;

  assign busy   = (state != IDLE);
  assign mem_we = (state == ISSUE) && store_q;
  assign mem_re = (state == ISSUE) && !store_q;

  always_comb begin
    rd32 = 32'(mem_rdata);
    if (NARROW && two_beat_q) raw_rd = {mem_rdata[15:0], lo_half_q};
    else                      raw_rd = rd32 >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    ext_rd = unsigned_q ? {24'h0, raw_rd[7:0]}
                                   : {{24{raw_rd[7]}}, raw_rd[7:0]};
      2'd1:    ext_rd = unsigned_q ? {16'h0, raw_rd[15:0]}
                                   : {{16{raw_rd[15]}}, raw_rd[15:0]};
      default: ext_rd = raw_rd;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (op_valid && !mis_in) state_d = ISSUE;
      ISSUE:   if (!mem_busy) begin
                 if (!store_q)       state_d = WAIT_R;
                 else if (last_beat) state_d = IDLE;
               end
      WAIT_R:  if (mem_rvalid) state_d = last_beat ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      done       <= 1'b0;
      misaligned <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      two_beat_q <= 1'b0;
      beat_q     <= 1'b0;
      size_q     <= '0;
      lane_q     <= '0;
      wdata_hi_q <= '0;
      lo_half_q  <= '0;
    end else begin
      state      <= state_d;
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: if (op_valid) begin
          if (mis_in) begin
            misaligned <= 1'b1;
          end else begin
            store_q    <= op_store;
            unsigned_q <= op_unsigned;
            size_q     <= size_n;
            lane_q     <= lane_in;
            two_beat_q <= NARROW && (size_n == 2'd2);
            beat_q     <= 1'b0;
            wdata_hi_q <= op_wdata[31:16];
            mem_addr   <= base_addr;
            mem_wdata  <= lane_wdata(size_n, op_wdata);
            mem_be     <= lane_be(size_n, lane_in);
          end
        end
        ISSUE: if (!mem_busy && store_q) begin
          if (last_beat) begin
            done <= 1'b1;
          end else begin
            beat_q    <= 1'b1;
            mem_addr  <= mem_addr + ADDR_WIDTH'(1);
            mem_wdata <= BUS_WIDTH'(wdata_hi_q);
          end
        end
        WAIT_R: if (mem_rvalid) begin
          if (last_beat) begin
            rdata <= ext_rd;
            done  <= 1'b1;
          end else begin
            lo_half_q <= mem_rdata[15:0];
            beat_q    <= 1'b1;
            mem_addr  <= mem_addr + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: one 32-bit-bus instance (a_*) and one 16-bit-bus
// instance (b_*). Expected write commands and load results are queued when
// an op is driven and popped when the DUT presents the command / done.
module tb_rv32i_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        a_op_valid, a_op_store, a_op_unsigned;
  logic [1:0]  a_op_size;
  logic [31:0] a_op_addr, a_op_wdata;
  logic        a_busy, a_done, a_mis, a_mem_we, a_mem_re;
  logic [31:0] a_rdata, a_mem_wdata, a_mem_rdata;
  logic [21:0] a_mem_addr;
  logic [3:0]  a_mem_be;
  logic        a_mem_busy, a_mem_rvalid;

  logic        b_op_valid, b_op_store, b_op_unsigned;
  logic [1:0]  b_op_size;
  logic [31:0] b_op_addr, b_op_wdata;
  logic        b_busy, b_done, b_mis, b_mem_we, b_mem_re;
  logic [31:0] b_rdata;
  logic [15:0] b_mem_wdata, b_mem_rdata;
  logic [21:0] b_mem_addr;
  logic [1:0]  b_mem_be;
  logic        b_mem_busy, b_mem_rvalid;

  rv32i_lsu #(.BUS_WIDTH(32), .ADDR_WIDTH(22)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .op_valid(a_op_valid), .op_store(a_op_store), .op_size(a_op_size),
    .op_unsigned(a_op_unsigned), .op_addr(a_op_addr), .op_wdata(a_op_wdata),
    .busy(a_busy), .done(a_done), .rdata(a_rdata), .misaligned(a_mis),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_re(a_mem_re),
    .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .mem_busy(a_mem_busy),
    .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata));

  rv32i_lsu #(.BUS_WIDTH(16), .ADDR_WIDTH(22)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .op_valid(b_op_valid), .op_store(b_op_store), .op_size(b_op_size),
    .op_unsigned(b_op_unsigned), .op_addr(b_op_addr), .op_wdata(b_op_wdata),
    .busy(b_busy), .done(b_done), .rdata(b_rdata), .misaligned(b_mis),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_re(b_mem_re),
    .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_busy(b_mem_busy),
    .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int b_re_cnt = 0;
  logic [31:0] a_last_rdata = 32'h0;

  always @(posedge clk) if (b_mem_re && !b_mem_busy) b_re_cnt <= b_re_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic a_drive(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] ad, input logic [31:0] wd);
    a_op_valid = 1'b1; a_op_store = st; a_op_size = sz;
    a_op_unsigned = uns; a_op_addr = ad; a_op_wdata = wd;
  endtask

  task automatic b_drive(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] ad, input logic [31:0] wd);
    b_op_valid = 1'b1; b_op_store = st; b_op_size = sz;
    b_op_unsigned = uns; b_op_addr = ad; b_op_wdata = wd;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({a_busy, a_done, a_mis, a_mem_we, a_mem_re} !== 5'b0)
      $display("FAIL reset_a_ctrl: got %b want 00000", {a_busy, a_done, a_mis, a_mem_we, a_mem_re});
    else n_pass++;
    n_checks++;
    if ({a_rdata, a_mem_addr, a_mem_wdata, a_mem_be} !== '0)
      $display("FAIL reset_a_data: rdata %h addr %h wdata %h be %b want all zero", a_rdata, a_mem_addr, a_mem_wdata, a_mem_be);
    else n_pass++;
    n_checks++;
    if ({b_busy, b_done, b_mis, b_mem_we, b_mem_re, b_rdata, b_mem_addr, b_mem_wdata, b_mem_be} !== '0)
      $display("FAIL reset_b: busy %b rdata %h addr %h wdata %h be %b want all zero", b_busy, b_rdata, b_mem_addr, b_mem_wdata, b_mem_be);
    else n_pass++;
  endtask

  task automatic a_store_check(input string name, input int wait_cycles);
    wr_t w;
    @(negedge clk);
    a_op_valid = 1'b0;
    w = wr_q.pop_front();
    n_checks++;
    if ({a_busy, a_mem_we, a_mem_re} !== 3'b110)
      $display("FAIL %s_cmd: busy/we/re %b want 110", name, {a_busy, a_mem_we, a_mem_re});
    else n_pass++;
    n_checks++;
    if ({10'h0, a_mem_addr} !== w.addr || a_mem_wdata !== w.data || a_mem_be !== w.be)
      $display("FAIL %s_fields: addr %h wdata %h be %b want %h %h %b", name, a_mem_addr, a_mem_wdata, a_mem_be, w.addr, w.data, w.be);
    else n_pass++;
    repeat (wait_cycles) @(negedge clk);
    n_checks++;
    if ({a_done, a_busy} !== 2'b10)
      $display("FAIL %s_done: done/busy %b want 10", name, {a_done, a_busy});
    else n_pass++;
  endtask

  task automatic test_store_word;
    wr_t w;
    @(negedge clk);
    a_drive(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    w.addr = 32'h40; w.data = 32'hDEADBEEF; w.be = 4'b1111;
    wr_q.push_back(w);
    a_store_check("store_word", 1);
  endtask

  task automatic test_store_byte;
    wr_t w;
    @(negedge clk);
    a_drive(1'b1, 2'd0, 1'b0, 32'h101, 32'h123456A5);
    w.addr = 32'h40; w.data = 32'hA5A5A5A5; w.be = 4'b0010;
    wr_q.push_back(w);
    a_store_check("store_byte", 1);
  endtask

  task automatic test_load_byte(input logic uns, input logic [31:0] exp);
    logic [31:0] e;
    @(negedge clk);
    a_drive(1'b0, 2'd0, uns, 32'h103, 32'h0);
    rd_q.push_back(exp);
    @(negedge clk);
    a_op_valid = 1'b0;
    n_checks++;
    if ({a_mem_re, a_mem_we, a_mem_addr, a_mem_be} !== {2'b10, 22'h40, 4'b1000})
      $display("FAIL load_byte_cmd: re %b we %b addr %h be %b want 1 0 40 1000", a_mem_re, a_mem_we, a_mem_addr, a_mem_be);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({a_mem_re, a_busy, a_done} !== 3'b010)
      $display("FAIL load_byte_wait: re/busy/done %b want 010", {a_mem_re, a_busy, a_done});
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h80FF1234;
    @(negedge clk);
    a_mem_rvalid = 1'b0; a_mem_rdata = 32'h0;
    e = rd_q.pop_front();
    a_last_rdata = e;
    n_checks++;
    if ({a_done, a_busy} !== 2'b10 || a_rdata !== e)
      $display("FAIL load_byte_u%0d: done %b busy %b rdata %h want 1 0 %h", uns, a_done, a_busy, a_rdata, e);
    else n_pass++;
  endtask

  task automatic test_misaligned;
    @(negedge clk);
    a_drive(1'b0, 2'd1, 1'b0, 32'h1, 32'h0);
    @(negedge clk);
    a_op_valid = 1'b0;
    n_checks++;
    if ({a_mis, a_busy, a_done, a_mem_re, a_mem_we} !== 5'b10000)
      $display("FAIL misaligned_pulse: mis/busy/done/re/we %b want 10000", {a_mis, a_busy, a_done, a_mem_re, a_mem_we});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({a_mis, a_busy, a_mem_re} !== 3'b000 || a_rdata !== a_last_rdata)
      $display("FAIL misaligned_after: mis/busy/re %b rdata %h want 000 %h", {a_mis, a_busy, a_mem_re}, a_rdata, a_last_rdata);
    else n_pass++;
  endtask

  task automatic test_stall_store;
    wr_t w;
    @(negedge clk);
    a_drive(1'b1, 2'd1, 1'b0, 32'h2, 32'h1234ABCD);
    a_mem_busy = 1'b1;
    w.addr = 32'h0; w.data = 32'hABCDABCD; w.be = 4'b1100;
    wr_q.push_back(w);
    w = wr_q.pop_front();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      a_op_valid = 1'b0;
      n_checks++;
      if (a_mem_we !== 1'b1 || a_done !== 1'b0 || {10'h0, a_mem_addr} !== w.addr ||
          a_mem_wdata !== w.data || a_mem_be !== w.be)
        $display("FAIL stall_hold_%0d: we %b done %b addr %h wdata %h be %b want 1 0 %h %h %b",
                 i, a_mem_we, a_done, a_mem_addr, a_mem_wdata, a_mem_be, w.addr, w.data, w.be);
      else n_pass++;
      if (i == 6) a_mem_busy = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({a_done, a_busy, a_mem_we} !== 3'b100)
      $display("FAIL stall_done: done/busy/we %b want 100", {a_done, a_busy, a_mem_we});
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    wr_t w;
    logic [31:0] e;
    @(negedge clk);
    a_drive(1'b1, 2'd2, 1'b0, 32'h200, 32'h0BADF00D);
    w.addr = 32'h80; w.data = 32'h0BADF00D; w.be = 4'b1111;
    wr_q.push_back(w);
    a_store_check("b2b_store", 1);
    a_drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    rd_q.push_back(32'hCAFEF00D);
    @(negedge clk);
    a_op_valid = 1'b0;
    n_checks++;
    if ({a_busy, a_mem_re, a_mem_addr} !== {2'b11, 22'h4})
      $display("FAIL b2b_load_cmd: busy %b re %b addr %h want 1 1 4", a_busy, a_mem_re, a_mem_addr);
    else n_pass++;
    a_mem_busy = 1'b1; a_mem_rvalid = 1'b1; a_mem_rdata = 32'h55555555;
    @(negedge clk);
    n_checks++;
    if ({a_mem_re, a_done} !== 2'b10)
      $display("FAIL b2b_stale_rvalid: re/done %b want 10", {a_mem_re, a_done});
    else n_pass++;
    a_mem_busy = 1'b0; a_mem_rvalid = 1'b0;
    @(negedge clk);
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    a_mem_rvalid = 1'b0; a_mem_rdata = 32'h0;
    e = rd_q.pop_front();
    a_last_rdata = e;
    n_checks++;
    if ({a_done, a_busy} !== 2'b10 || a_rdata !== e)
      $display("FAIL b2b_load_done: done %b busy %b rdata %h want 1 0 %h", a_done, a_busy, a_rdata, e);
    else n_pass++;
  endtask

  task automatic test_bus16_load_word;
    int cnt0;
    logic [31:0] e;
    @(negedge clk);
    cnt0 = b_re_cnt;
    b_drive(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    rd_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    b_op_valid = 1'b0;
    n_checks++;
    if ({b_mem_re, b_mem_addr, b_mem_be} !== {1'b1, 22'h4, 2'b11})
      $display("FAIL b16_lw_beat0: re %b addr %h be %b want 1 4 11", b_mem_re, b_mem_addr, b_mem_be);
    else n_pass++;
    @(negedge clk);
    b_mem_rvalid = 1'b1; b_mem_rdata = 16'hBEEF;
    @(negedge clk);
    b_mem_rvalid = 1'b0; b_mem_rdata = 16'h0;
    n_checks++;
    if ({b_mem_re, b_done, b_mem_addr} !== {2'b10, 22'h5})
      $display("FAIL b16_lw_beat1: re %b done %b addr %h want 1 0 5", b_mem_re, b_done, b_mem_addr);
    else n_pass++;
    @(negedge clk);
    b_mem_rvalid = 1'b1; b_mem_rdata = 16'hDEAD;
    @(negedge clk);
    b_mem_rvalid = 1'b0; b_mem_rdata = 16'h0;
    e = rd_q.pop_front();
    n_checks++;
    if ({b_done, b_busy} !== 2'b10 || b_rdata !== e)
      $display("FAIL b16_lw_done: done %b busy %b rdata %h want 1 0 %h", b_done, b_busy, b_rdata, e);
    else n_pass++;
    n_checks++;
    if (b_re_cnt - cnt0 !== 2)
      $display("FAIL b16_lw_accepts: got %0d want 2", b_re_cnt - cnt0);
    else n_pass++;
  endtask

  task automatic test_bus16_store_word;
    wr_t w;
    @(negedge clk);
    b_drive(1'b1, 2'd2, 1'b0, 32'h4, 32'h12345678);
    w.addr = 32'h2; w.data = 32'h5678; w.be = 4'b0011;
    wr_q.push_back(w);
    w.addr = 32'h3; w.data = 32'h1234;
    wr_q.push_back(w);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b_op_valid = 1'b0;
      w = wr_q.pop_front();
      n_checks++;
      if (b_mem_we !== 1'b1 || b_done !== 1'b0 || {10'h0, b_mem_addr} !== w.addr ||
          {16'h0, b_mem_wdata} !== w.data || {2'b00, b_mem_be} !== w.be)
        $display("FAIL b16_sw_beat%0d: we %b done %b addr %h wdata %h be %b want 1 0 %h %h %b",
                 i, b_mem_we, b_done, b_mem_addr, b_mem_wdata, b_mem_be, w.addr, w.data, w.be);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({b_done, b_busy, b_mem_we} !== 3'b100)
      $display("FAIL b16_sw_done: done/busy/we %b want 100", {b_done, b_busy, b_mem_we});
    else n_pass++;
  endtask

  task automatic test_bus16_byte;
    logic [31:0] e;
    @(negedge clk);
    b_drive(1'b0, 2'd0, 1'b0, 32'h5, 32'h0);
    rd_q.push_back(32'hFFFFFF9C);
    @(negedge clk);
    b_op_valid = 1'b0;
    n_checks++;
    if ({b_mem_re, b_mem_addr, b_mem_be} !== {1'b1, 22'h2, 2'b10})
      $display("FAIL b16_lb_cmd: re %b addr %h be %b want 1 2 10", b_mem_re, b_mem_addr, b_mem_be);
    else n_pass++;
    @(negedge clk);
    b_mem_rvalid = 1'b1; b_mem_rdata = 16'h9C12;
    @(negedge clk);
    b_mem_rvalid = 1'b0; b_mem_rdata = 16'h0;
    e = rd_q.pop_front();
    n_checks++;
    if (b_done !== 1'b1 || b_rdata !== e)
      $display("FAIL b16_lb_done: done %b rdata %h want 1 %h", b_done, b_rdata, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    wr_t w;
    @(negedge clk);
    a_drive(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    a_op_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_busy, a_mem_re} !== 2'b10)
      $display("FAIL rst_mid_wait: busy/re %b want 10", {a_busy, a_mem_re});
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({a_busy, a_done, a_mis, a_mem_we, a_mem_re, a_rdata, a_mem_addr, a_mem_wdata, a_mem_be} !== '0)
      $display("FAIL rst_mid_clear: busy %b rdata %h addr %h wdata %h be %b want all zero",
               a_busy, a_rdata, a_mem_addr, a_mem_wdata, a_mem_be);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h77777777;
    @(negedge clk);
    a_mem_rvalid = 1'b0; a_mem_rdata = 32'h0;
    n_checks++;
    if ({a_done, a_busy, a_rdata} !== 34'h0)
      $display("FAIL rst_mid_spurious: done %b busy %b rdata %h want 0 0 0", a_done, a_busy, a_rdata);
    else n_pass++;
    a_drive(1'b1, 2'd2, 1'b0, 32'h0, 32'h11112222);
    w.addr = 32'h0; w.data = 32'h11112222; w.be = 4'b1111;
    wr_q.push_back(w);
    a_store_check("rst_mid_next", 1);
  endtask

  initial begin
    reset_n = 1'b0;
    a_op_valid = 0; a_op_store = 0; a_op_size = 0; a_op_unsigned = 0;
    a_op_addr = 0; a_op_wdata = 0;
    a_mem_busy = 0; a_mem_rvalid = 0; a_mem_rdata = 0;
    b_op_valid = 0; b_op_store = 0; b_op_size = 0; b_op_unsigned = 0;
    b_op_addr = 0; b_op_wdata = 0;
    b_mem_busy = 0; b_mem_rvalid = 0; b_mem_rdata = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_byte(1'b0, 32'hFFFFFF80);
    test_load_byte(1'b1, 32'h00000080);
    test_misaligned();
    test_stall_store();
    test_back_to_back();
    test_bus16_load_word();
    test_bus16_store_word();
    test_bus16_byte();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
